pc_unit_ras: RTL
================

// Module: pc_unit_ras
// PURPOSE
//   Program-counter unit for the single-cycle core: holds the PC register and selects the
//   next PC each cycle.
//   Sources: sequential PC+2, condition-coded PC-relative branch, or register-indirect branch.
//   Adds stall/halt control and a return-address stack (RAS) for call/return.
//   Sits between instruction fetch (drives imem address) and decode/flag register.
// PARAMETERS
//   PC_W      16  PC / address width in bits
//   IMM_W     9   branch immediate width (signed, halfword offset)
//   RAS_DEPTH 4   return-address stack entries (power of 2, >=2)
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   stall        in   1      hold PC and RAS this cycle
//   halt         in   1      HLT decoded; freeze PC until reset
//   br_imm_en    in   1      PC-relative conditional branch (B)
//   br_reg_en    in   1      register-indirect conditional branch (BR)
//   call         in   1      qualifies a taken B/BR as a call (push return address)
//   ret          in   1      return: pop RAS into PC
//   cond         in   3      branch condition code
//   flag         in   3      {V,Z,N}: flag[0]=N, flag[1]=Z, flag[2]=V
//   imm          in   IMM_W  signed branch offset in halfwords
//   reg_target   in   PC_W   target for br_reg_en
//   pc           out  PC_W   current PC (registered)
//   pc_plus2     out  PC_W   pc+2 (combinational, for link/writeback)
//   taken        out  1      combinational: next PC is not pc+2 this cycle
//   halted       out  1      registered: unit in HALT state
//   ras_empty    out  1      RAS holds no entries
//   ras_ovf      out  1      sticky: push occurred while full
//   ras_unf      out  1      sticky: ret occurred while empty
// BEHAVIOUR
// - Reset (async, any time, incl. mid-stall/halt):
//   - pc=RESET_PC, halted=0, RAS count=0, ras_empty=1, ras_ovf=0, ras_unf=0.
// - Condition met (cond_ok), by cond:
//   - 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 Z|!N; 101 N|Z; 110 V; 111 always.
// - Arithmetic:
//   - pc_plus2 = pc+2, mod 2^PC_W.
//   - rel_tgt = pc_plus2 + (sext(imm)<<1), mod 2^PC_W; wrap-around silently, no flag.
// - FSM, 2 states:
//   - RUN: normal operation.
//   - HALT: entered on the edge where halt=1 & stall=0; leaves only on rst.
//   - halted=1 from the cycle after entry.
//   - In HALT: pc, RAS and sticky flags frozen; taken=0; all inputs ignored.
// - Next-PC priority in RUN (first match wins), committed at the rising edge, 1-cycle latency:
//   1 stall: pc held, RAS held, taken=0.
//   2 halt: pc held, enter HALT.
//   3 ret: pc<=RAS top, pop.
//     - If empty: pc<=pc_plus2, ras_unf<=1, taken=0.
//     - call/br inputs ignored this cycle.
//   4 br_reg_en & cond_ok: pc<=reg_target.
//   5 br_imm_en & cond_ok: pc<=rel_tgt.
//     - br_reg_en has priority if both are asserted.
//   6 otherwise: pc<=pc_plus2.
// - Call: when 4 or 5 is taken and call=1, push pc_plus2.
//   - An untaken call pushes nothing.
// - RAS is a circular stack with a top pointer and count.
//   - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, ras_ovf<=1.
//   - ras_empty = (count==0).
//   - Stack contents are not reset; only pointers and count are.
// - Sticky flags clear only on rst.
// - taken is combinational on current inputs and state. It is 1 in cases 3 (non-empty) to 5 when
//   the target is selected, even if the target equals pc_plus2.
// TESTING
//   T1 rst mid-run with pc=0x0040 -> pc=0x0000 immediately (async); halted=0, ras_empty=1.
//   T2 pc=0x0010, br_imm_en, cond=001, Z=1, imm=9'h1FE (-2) -> next pc=0x000E, taken=1.
//      Same with Z=0 -> 0x0012, taken=0.
//   T3 pc=0xFFFE, sequential -> pc=0x0000 (wrap).
//      pc=0xFFF0, imm=+16 taken -> 0x0012.
//   T4 RAS_DEPTH=4: five taken calls from pcs 0x10,0x20,0x30,0x40,0x50 -> ras_ovf=1.
//      Four rets -> pc 0x52,0x42,0x32,0x22; then ras_empty=1.
//      Fifth ret -> pc=pc+2, ras_unf=1.
//   T5 stall=1 with br_reg_en, call, reg_target=0x0100 -> pc and RAS unchanged, taken=0.
//      Release stall -> pc=0x0100, return address pushed.
//   T6 halt at pc=0x0020 with br_imm_en cond=111 -> pc stays 0x0020, halted=1 next cycle.
//      Further branches/rets ignored; rst -> pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/pc_unit_ras.sv
// Program-counter unit: PC register, next-PC select (sequential / relative / indirect),
// stall and halt control, and a circular return-address stack for call/return.
module pc_unit_ras #(
  parameter int              PC_W      = 16,
  parameter int              IMM_W     = 9,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_imm_en,
  input  logic             br_reg_en,
  input  logic             call,
  input  logic             ret,
  input  logic [2:0]       cond,
  input  logic [2:0]       flag,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  reg_target,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             taken,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [PC_W-1:0] ras_mem [RAS_DEPTH];

  logic [PC_W-1:0] imm_ext, rel_tgt, ras_top;
  logic            cond_ok, push;

  always_comb begin
    pc_plus2 = pc_q + PC_W'(2);
    imm_ext  = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    rel_tgt  = pc_plus2 + (imm_ext << 1);
    ras_top  = ras_mem[top_q];
  end

  // flag = {V,Z,N}
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      3'b000:  cond_ok = !flag[1];
      3'b001:  cond_ok = flag[1];
      3'b010:  cond_ok = !flag[1] && !flag[0];
      3'b011:  cond_ok = flag[0];
      3'b100:  cond_ok = flag[1] || !flag[0];
      3'b101:  cond_ok = flag[0] || flag[1];
      3'b110:  cond_ok = flag[2];
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    taken   = 1'b0;
    push    = 1'b0;
    if (state_q == RUN && !stall) begin
      if (halt) begin
        state_d = HALT;
      end else if (ret) begin
        if (cnt_q == '0) begin
          pc_d  = pc_plus2;
          unf_d = 1'b1;
        end else begin
          pc_d  = ras_top;
          taken = 1'b1;
          top_d = top_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        pc_d = pc_plus2;
        if (br_reg_en && cond_ok) begin
          pc_d  = reg_target;
          taken = 1'b1;
        end else if (br_imm_en && cond_ok) begin
          pc_d  = rel_tgt;
          taken = 1'b1;
        end
        // When full, the slot after top is the oldest entry, so it is overwritten.
        if (taken && call) begin
          push  = 1'b1;
          top_d = top_q + PW'(1);
          if (cnt_q == RAS_FULL) ovf_d = 1'b1;
          else                   cnt_d = cnt_q + CW'(1);
        end
      end
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      top_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      top_q    <= top_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Stack storage carries no reset; only pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (push) ras_mem[top_d] <= pc_plus2;
  end

  assign pc        = pc_q;
  assign halted    = halted_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule
